ux607_uartrx_fifo: RTL
======================

// Module: ux607_uartrx_fifo
// PURPOSE
//  Receive FIFO directly downstream of the UART receiver (uartrx) in the UART peripheral.
//  Captures each valid byte from the receiver and buffers it until the bus-register read path pops it.
//  Generates the RX watermark interrupt pending bit and a sticky overflow flag.
//  The receiver has no backpressure; this block never stalls it and drops bytes when full.
// PARAMETERS
//  DEPTH  8  entries; power of two, 2..64
//  WIDTH  8  data bits per entry
//  CW     $clog2(DEPTH)+1  count width (localparam, derived from DEPTH)
// PORTS
//  clock         in   1        single clock; all state on rising edge
//  reset_n       in   1        asynchronous, active-low reset
//  io_en         in   1        receive enable; 0 flushes the FIFO
//  io_enq_valid  in   1        one-cycle byte strobe from uartrx out_valid
//  io_enq_bits   in   WIDTH    byte from uartrx out_bits
//  io_deq_ready  in   1        register read pops the head entry
//  io_deq_valid  out  1        FIFO non-empty
//  io_deq_bits   out  WIDTH    head entry; 0 when empty
//  io_count      out  CW       occupancy, 0..DEPTH
//  io_rxwm       in   CW-1     watermark; 0..DEPTH-1
//  io_ip_rxwm    out  1        pending: count > rxwm (registered)
//  io_ovf        out  1        sticky overflow flag
//  io_ovf_clr    in   1        one-cycle clear of io_ovf
// BEHAVIOUR
//  Reset (reset_n=0, async): rd/wr pointers=0, count=0, io_ip_rxwm=0, io_ovf=0, io_deq_valid=0.
//    Storage array is not reset. Reset mid-transfer discards all contents.
//  Pointers are log2(DEPTH) bits and wrap DEPTH-1 -> 0 naturally. count tracks occupancy explicitly.
//  Push = io_enq_valid & io_en & (~full | pop).
//    Write entry[wr_ptr]; wr_ptr+1.
//  Pop = io_deq_ready & io_deq_valid. rd_ptr+1.
//  Latency: a byte pushed in cycle N is visible on io_deq_bits in cycle N+1. No same-cycle bypass.
//  Simultaneous push and pop:
//    - count unchanged.
//    - When full, the pop frees the slot and the push is accepted.
//    - When empty, pop is invalid, so only the push occurs.
//  io_deq_ready while empty: no effect; pointers and count hold.
//  Overflow: io_enq_valid & io_en & full & ~pop -> byte dropped, io_ovf<=1. FIFO contents unchanged.
//  io_ovf_clr: io_ovf<=0. Same-cycle set and clear -> set wins.
//  io_en=0: pointers and count <=0 next cycle. Enqueues are ignored. io_ovf is retained.
//  io_ip_rxwm <= (count_next > io_rxwm). Updates one cycle after the occupancy change, with no combinational path from io_rxwm.
//    io_rxwm >= DEPTH is treated as DEPTH-1.
//  io_deq_bits = entry[rd_ptr] when non-empty, else 0 (gated, no X leakage to the bus).
//  io_count is registered; it equals the number of held entries.
// STRUCTURE
//  Shared package ux607_uart_pkg:
//    - UART_DATA_W = 8 and UART_RXFIFO_DEPTH = 8 constants.
//    - Register-offset constants: RXDATA, RXCTRL, IP.
//    - Bit-position constants for the rxwm field and the ip_rxwm bit, shared with uarttx and the register block.
//  One sub-module: ux607_uart_fifo_ram.
//    - DEPTH x WIDTH flop array; write port plus asynchronous read port.
//    - Reusable by the TX FIFO.
//  Pointer, count, flag and interrupt logic live in this module.
// TESTING
//  1. Reset, then push 0x41,0x42,0x43 on separate cycles, then pop 3 -> deq_bits 0x41,0x42,0x43 in order; count 3->0; deq_valid=0 after.
//  2. Push 9 bytes 0x00..0x08, no pops -> count=8, ovf=1 after 9th, pops return 0x00..0x07 (0x08 dropped).
//  3. FIFO full, push 0x55 and pop in same cycle -> count stays 8, ovf stays 0, 0x55 returned last.
//  4. rxwm=2: push 3 bytes -> ip_rxwm=1 one cycle after the 3rd push; pop 1 -> ip_rxwm=0 next cycle.
//  5. 5 entries held, io_en=0 for 1 cycle with concurrent enq_valid -> count=0, deq_valid=0, enq ignored, ovf unchanged.
//  6. Pop from empty with deq_ready=1 -> pointers hold, deq_bits=0.
//     Then assert reset_n=0 asynchronously mid-stream -> all outputs 0 without waiting for a clock edge.
//     Wrap check: 20 push/pop pairs -> data intact across pointer wrap.

Source files
------------

// File: rtl/ux607_uart_pkg.sv
// Shared UART constants: data width, FIFO depth, register offsets and field positions.
// Used by the RX/TX FIFOs and the register block so all agree on layout.
package ux607_uart_pkg;

    // Datapath and buffering
    localparam int UART_DATA_W       = 8;
    localparam int UART_RXFIFO_DEPTH = 8;

    // Register offsets within the UART peripheral
    localparam logic [7:0] UART_REG_RXDATA = 8'h04;
    localparam logic [7:0] UART_REG_RXCTRL = 8'h0C;
    localparam logic [7:0] UART_REG_IP     = 8'h14;

    // Field and bit positions
    localparam int UART_RXCTRL_RXWM_LSB = 16;
    localparam int UART_RXCTRL_RXWM_W   = 3;
    localparam int UART_IP_RXWM_BIT     = 1;

endpackage

// File: rtl/ux607_uart_fifo_ram.sv
// DEPTH x WIDTH flop storage with one synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module ux607_uart_fifo_ram #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Write the addressed entry when enabled; storage holds otherwise.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ux607_uartrx_fifo.sv
// UART receive FIFO: buffers bytes from the receiver (no backpressure; drops
// when full and flags overflow), raises the RX watermark pending bit, and
// presents the head byte to the register read path.
module ux607_uartrx_fifo
    import ux607_uart_pkg::*;
#(
    parameter  int DEPTH = UART_RXFIFO_DEPTH,
    parameter  int WIDTH = UART_DATA_W,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             io_en,
    input  logic             io_enq_valid,
    input  logic [WIDTH-1:0] io_enq_bits,
    input  logic             io_deq_ready,
    output logic             io_deq_valid,
    output logic [WIDTH-1:0] io_deq_bits,
    output logic [CW-1:0]    io_count,
    input  logic [CW-2:0]    io_rxwm,
    output logic             io_ip_rxwm,
    output logic             io_ovf,
    input  logic             io_ovf_clr
);

    localparam int AW = CW - 1;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_deq_valid;
    logic             r_ip_rxwm;
    logic             r_ovf;

    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_ovf_set;
    logic [AW-1:0]    w_wr_ptr_next;
    logic [AW-1:0]    w_rd_ptr_next;
    logic [CW-1:0]    w_count_next;
    logic [CW-1:0]    w_rxwm_wide;
    logic [CW-1:0]    w_rxwm_eff;
    logic [WIDTH-1:0] w_rdata;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop     = io_deq_ready & r_deq_valid;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_push    = io_enq_valid & io_en & (~w_full | w_pop);
    assign w_ovf_set = io_enq_valid & io_en & w_full & ~w_pop;

    assign w_rxwm_wide = {1'b0, io_rxwm};

    // Clamp the watermark to DEPTH-1 so a full FIFO always raises the interrupt.
    always_comb begin
        w_rxwm_eff = w_rxwm_wide;
        if (w_rxwm_wide >= CW'(DEPTH)) begin
            w_rxwm_eff = CW'(DEPTH - 1);
        end else begin
            w_rxwm_eff = w_rxwm_wide;
        end
    end

    // Next pointers and occupancy; a disabled receiver flushes everything.
    always_comb begin
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        w_count_next  = r_count;
        if (!io_en) begin
            w_wr_ptr_next = {AW{1'b0}};
            w_rd_ptr_next = {AW{1'b0}};
            w_count_next  = {CW{1'b0}};
        end else begin
            if (w_push) begin
                w_wr_ptr_next = r_wr_ptr + AW'(1);
            end else begin
                w_wr_ptr_next = r_wr_ptr;
            end
            if (w_pop) begin
                w_rd_ptr_next = r_rd_ptr + AW'(1);
            end else begin
                w_rd_ptr_next = r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   w_count_next = r_count + CW'(1);
                2'b01:   w_count_next = r_count - CW'(1);
                default: w_count_next = r_count;
            endcase
        end
    end

    // Pointer, occupancy, status and sticky overflow registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr    <= {AW{1'b0}};
            r_rd_ptr    <= {AW{1'b0}};
            r_count     <= {CW{1'b0}};
            r_deq_valid <= 1'b0;
            r_ip_rxwm   <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_wr_ptr    <= w_wr_ptr_next;
            r_rd_ptr    <= w_rd_ptr_next;
            r_count     <= w_count_next;
            r_deq_valid <= (w_count_next != {CW{1'b0}});
            r_ip_rxwm   <= (w_count_next > w_rxwm_eff);
            // A new overflow beats a simultaneous clear so no event is lost.
            if (w_ovf_set) begin
                r_ovf <= 1'b1;
            end else if (io_ovf_clr) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    ux607_uart_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH),
        .AW    (AW)
    ) u_ram (
        .clock   (clock),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata (io_enq_bits),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rdata)
    );

    assign io_deq_valid = r_deq_valid;
    // Gate the head so stale or uninitialised storage never reaches the bus.
    assign io_deq_bits  = r_deq_valid ? w_rdata : {WIDTH{1'b0}};
    assign io_count     = r_count;
    assign io_ip_rxwm   = r_ip_rxwm;
    assign io_ovf       = r_ovf;

endmodule
